jk_count_driver: RTL and testbench

//  Upstream controller for a bank of WIDTH negedge-clocked JK flip-flops (active-high CLR).

---
 rtl/jk_count_driver.sv | 118 +++++++++++
 tb/tb_jk_count_driver.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/jk_count_driver.sv
// Upstream controller for a bank of negedge-clocked JK flip-flops: keeps a shadow
// modulo-MODULUS count and drives one-cycle J/K excitation so the bank follows it.
module jk_count_driver #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 10
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] ld_val,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             bank_clr,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ready,
  output logic             err
);

  localparam int unsigned           CW      = WIDTH + 1;
  localparam logic [WIDTH-1:0]      MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [CW-1:0]         MOD_EXT = CW'(MODULUS);

  if ((MODULUS < 2) || (MODULUS > (2 ** WIDTH))) begin : g_bad_modulus
    $error("jk_count_driver: MODULUS must lie in 2..2**WIDTH");
  end

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_SYNC  = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [WIDTH-1:0] j_q, j_d;
  logic [WIDTH-1:0] k_q, k_d;
  logic             bank_clr_q, bank_clr_d;
  logic             err_q, err_d;
  logic             ready_q, ready_d;
  logic [WIDTH-1:0] nxt;

  // State and registered outputs; reset also drops any pending J/K step.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q    <= ST_CLEAR;
      s_q        <= '0;
      j_q        <= '0;
      k_q        <= '0;
      bank_clr_q <= 1'b1;
      err_q      <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      s_q        <= s_d;
      j_q        <= j_d;
      k_q        <= k_d;
      bank_clr_q <= bank_clr_d;
      err_q      <= err_d;
      ready_q    <= ready_d;
    end
  end

  // Next count value: load beats step, out-of-range loads map to zero.
  always_comb begin
    nxt = s_q;
    if (load) begin
      nxt = ({1'b0, ld_val} < MOD_EXT) ? ld_val : '0;
    end else if (en && up) begin
      nxt = (s_q == MAX_VAL) ? '0 : s_q + WIDTH'(1);
    end else if (en) begin
      nxt = (s_q == '0) ? MAX_VAL : s_q - WIDTH'(1);
    end
  end

  // Sequencing and excitation; J/K default to zero so each step lasts one cycle.
  always_comb begin
    state_d    = state_q;
    s_d        = s_q;
    j_d        = '0;
    k_d        = '0;
    bank_clr_d = 1'b0;
    err_d      = err_q;
    ready_d    = 1'b0;
    unique case (state_q)
      ST_CLEAR: begin
        state_d = ST_SYNC;
      end
      ST_SYNC: begin
        state_d = ST_RUN;
        if (q_fb != '0) err_d = 1'b1;
      end
      ST_RUN: begin
        s_d = nxt;
        j_d = ~s_q & nxt;
        k_d = s_q & ~nxt;
        if (q_fb != s_q) err_d = 1'b1;
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase
    ready_d = (state_d == ST_RUN);
  end

  assign j        = j_q;
  assign k        = k_q;
  assign bank_clr = bank_clr_q;
  assign count    = s_q;
  assign ready    = ready_q;
  assign err      = err_q;
  assign tc       = ready_q & ~load & en &
                    ((up & (s_q == MAX_VAL)) | (~up & (s_q == '0)));

endmodule

// File: tb/tb_jk_count_driver.sv
// Bench for jk_count_driver: a behavioural JK bank closes the loop, and a count-level
// model predicts every output after each clock edge.
module tb_jk_count_driver;

  localparam int unsigned W   = 4;
  localparam int          MOD = 10;

  logic         clk;
  logic         clr_n, en, up, load;
  logic [W-1:0] ld_val, q_fb, j, k, count;
  logic         bank_clr, tc, ready, err;
  logic [W-1:0] bank_q;
  logic [W-1:0] stuck;

  int checks = 0;
  int errors = 0;
  int m_cnt  = 0;
  int m_rel  = 0;
  bit m_err  = 1'b0;

  jk_count_driver #(.WIDTH(W), .MODULUS(MOD)) dut (
    .clk(clk), .clr_n(clr_n), .en(en), .up(up), .load(load), .ld_val(ld_val),
    .q_fb(q_fb), .j(j), .k(k), .bank_clr(bank_clr), .count(count), .tc(tc),
    .ready(ready), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // JK bank: negedge clocked, active-high clear, stuck-at-1 mask on its outputs.
  assign q_fb = bank_q | stuck;
  always @(negedge clk) begin
    for (int b = 0; b < W; b++) begin
      if (bank_clr) bank_q[b] <= 1'b0;
      else begin
        case ({j[b], k[b]})
          2'b10:   bank_q[b] <= 1'b1;
          2'b01:   bank_q[b] <= 1'b0;
          2'b11:   bank_q[b] <= ~bank_q[b];
          default: bank_q[b] <= bank_q[b];
        endcase
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock cycle: apply inputs, check tc, then check all registered outputs after the edge.
  task automatic step(input logic rn, input logic e, input logic u, input logic l,
                      input logic [W-1:0] lv);
    logic [W-1:0] qcap;
    int n, ej, ek, ebc;
    bit exp_tc;
    clr_n = rn; en = e; up = u; load = l; ld_val = lv;
    #1;
    exp_tc = (m_rel >= 2) && !l && e && (u ? (m_cnt == MOD - 1) : (m_cnt == 0));
    chk("tc", 32'(tc), 32'(exp_tc));
    @(posedge clk);
    qcap = q_fb;
    if (m_rel >= 1 && stuck == '0) chk("q_fb", 32'(qcap), 32'(m_cnt));
    #1;
    ej = 0; ek = 0; ebc = 0;
    if (!rn) begin
      m_rel = 0; m_cnt = 0; m_err = 1'b0; ebc = 1;
    end else if (m_rel == 0) begin
      m_rel = 1;
    end else if (m_rel == 1) begin
      m_rel = 2;
      if (qcap != '0) m_err = 1'b1;
    end else begin
      if (32'(qcap) != m_cnt) m_err = 1'b1;
      if (l)      n = (int'(lv) < MOD) ? int'(lv) : 0;
      else if (e) n = u ? (m_cnt + 1) % MOD : (m_cnt + MOD - 1) % MOD;
      else        n = m_cnt;
      ej = n & ~m_cnt & 15;
      ek = m_cnt & ~n & 15;
      m_cnt = n;
    end
    chk("count", 32'(count), 32'(m_cnt));
    chk("j", 32'(j), 32'(ej));
    chk("k", 32'(k), 32'(ek));
    chk("bank_clr", 32'(bank_clr), 32'(ebc));
    chk("ready", 32'(ready), 32'(m_rel == 2));
    chk("err", 32'(err), 32'(m_err));
  endtask

  initial begin
    stuck = '0;
    clr_n = 1'b0; en = 1'b0; up = 1'b0; load = 1'b0; ld_val = '0;
    @(posedge clk);
    #1;

    // 1: reset held three cycles, then release
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    chk("t1_ready_early", 32'(ready), 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    chk("t1_ready", 32'(ready), 32'd1);

    // 2: twelve up steps through the wrap
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
      if (i == 9) begin
        chk("t2_wrap_j", 32'(j), 32'd0);
        chk("t2_wrap_k", 32'(k), 32'd9);
      end
    end
    chk("t2_count", 32'(count), 32'd2);

    // 3: down from zero wraps to nine
    step(1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    chk("t3_count", 32'(count), 32'd9);
    chk("t3_j", 32'(j), 32'd9);
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);

    // 4: load beats enable, then up, then out-of-range load
    step(1'b1, 1'b1, 1'b1, 1'b1, 4'd7);
    chk("t4_load", 32'(count), 32'd7);
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
    chk("t4_j", 32'(j), 32'd8);
    chk("t4_k", 32'(k), 32'd7);
    step(1'b1, 1'b0, 1'b0, 1'b1, 4'd12);
    chk("t4_oor", 32'(count), 32'd0);

    // 5: stuck feedback bit sets a sticky error, counting continues
    stuck = 4'b0010;
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    stuck = '0;
    chk("t5_err", 32'(err), 32'd1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
    chk("t5_count", 32'(count), 32'd3);

    // 6: reset in the middle of a step
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
    chk("t6_j_pending", 32'(j), 32'd4);
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    chk("t6_bank_q", 32'(q_fb), 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);

    // random traffic, with occasional resets
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 64) != 0, ($urandom % 4) != 0, 1'($urandom % 2),
           ($urandom % 8) == 0, 4'($urandom % 16));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
